// File: rtl/bram_arbiter.sv
// bram_arbiter: shares the single-port data block RAM between the core memory
// stage (port C, priority) and the program/data loader (port L).
// Optional feature: define ARB_STARVE_GUARD_EN to add the loader wait counter
// and forced grant after MAX_WAIT cycles. Default build uses strict C priority.
module bram_arbiter #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned MAX_WAIT = 8
) (
   input  logic              clk,
   input  logic              rst,
   // core memory stage
   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   output logic              c_stall,
   output logic              c_rvalid,
   output logic [DATA_W-1:0] c_rdata,
   // loader
   input  logic              l_req,
   input  logic              l_we,
   input  logic [ADDR_W-1:0] l_addr,
   input  logic [DATA_W-1:0] l_wdata,
   output logic              l_gnt,
   output logic              l_rvalid,
   output logic [DATA_W-1:0] l_rdata,
   // block RAM
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_di,
   input  logic [DATA_W-1:0] ram_dout
);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_C    = 2'd1,
      OWN_L    = 2'd2
   } owner_t;

   owner_t rd_owner;
   logic   grant_c;
   logic   grant_l;
   logic   force_grant;

`ifdef ARB_STARVE_GUARD_EN
   localparam int unsigned CNT_W = 8;

   logic [CNT_W-1:0] wait_cnt;

   // Count cycles the loader has been kept waiting, saturating at MAX_WAIT.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (!l_req || grant_l) begin
         wait_cnt <= '0;
      end else if (wait_cnt < CNT_W'(MAX_WAIT)) begin
         wait_cnt <= wait_cnt + CNT_W'(1);
      end
   end

   assign force_grant = l_req && (wait_cnt == CNT_W'(MAX_WAIT));
`else
   assign force_grant = 1'b0;
`endif

   // Per-cycle arbitration: forced loader grant, then core, then loader.
   always_comb begin
      grant_c = 1'b0;
      grant_l = 1'b0;
      if (force_grant) begin
         grant_l = 1'b1;
      end else if (c_req) begin
         grant_c = 1'b1;
      end else if (l_req) begin
         grant_l = 1'b1;
      end
   end

   assign c_stall = c_req && !grant_c;
   assign l_gnt   = grant_l;

   // Route the winner's access to the RAM; idle bus is driven to zero.
   always_comb begin
      ram_en   = 1'b0;
      ram_we   = 1'b0;
      ram_addr = '0;
      ram_di   = '0;
      if (grant_c) begin
         ram_en   = 1'b1;
         ram_we   = c_we;
         ram_addr = c_addr;
         ram_di   = c_wdata;
      end else if (grant_l) begin
         ram_en   = 1'b1;
         ram_we   = l_we;
         ram_addr = l_addr;
         ram_di   = l_wdata;
      end
   end

   // Remember who owns the read data returning from the RAM next cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_owner <= OWN_NONE;
      end else if (grant_c && !c_we) begin
         rd_owner <= OWN_C;
      end else if (grant_l && !l_we) begin
         rd_owner <= OWN_L;
      end else begin
         rd_owner <= OWN_NONE;
      end
   end

   // Read data is shared; the valid flags (masked during reset) qualify it.
   assign c_rvalid = (rd_owner == OWN_C) && !rst;
   assign l_rvalid = (rd_owner == OWN_L) && !rst;
   assign c_rdata  = ram_dout;
   assign l_rdata  = ram_dout;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed self-checking bench for bram_arbiter with a 1-cycle registered RAM model.
// Build with ARB_STARVE_GUARD_EN defined to exercise the forced-grant path.
module tb_bram_arbiter;

   localparam int unsigned ADDR_W   = 32;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned MAX_WAIT = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              c_req, c_we;
   logic [ADDR_W-1:0] c_addr;
   logic [DATA_W-1:0] c_wdata;
   logic              c_stall, c_rvalid;
   logic [DATA_W-1:0] c_rdata;
   logic              l_req, l_we;
   logic [ADDR_W-1:0] l_addr;
   logic [DATA_W-1:0] l_wdata;
   logic              l_gnt, l_rvalid;
   logic [DATA_W-1:0] l_rdata;
   logic              ram_en, ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_di;
   logic [DATA_W-1:0] ram_dout;

   logic [DATA_W-1:0] mem [0:255];

   int total = 0;
   int bad   = 0;

   bram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst(rst),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
      .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
      .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di),
      .ram_dout(ram_dout)
   );

   always #5 clk = ~clk;

   // Word-addressed registered RAM model.
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr[9:2]] <= ram_di;
         else        ram_dout <= mem[ram_addr[9:2]];
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Inputs change at the falling edge; outputs are sampled 2 ns later.
   task automatic next_cycle();
      @(negedge clk);
   endtask

   task automatic settle();
      #2;
   endtask

   int lg_cnt;
   int st_cnt;

   initial begin
      rst = 1'b1;
      c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
      l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
      ram_dout = '0;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[8'h04] = 32'hDEADBEEF;   // 0x10
      mem[8'h00] = 32'h11111111;   // 0x0
      mem[8'h01] = 32'h22222222;   // 0x4
      mem[8'h02] = 32'h33333333;   // 0x8

      // Reset state
      next_cycle(); next_cycle(); settle();
      chk("rst_c_rvalid", 64'(c_rvalid), 64'd0);
      chk("rst_l_rvalid", 64'(l_rvalid), 64'd0);
      chk("rst_c_stall",  64'(c_stall),  64'd0);
      chk("rst_l_gnt",    64'(l_gnt),    64'd0);
      chk("rst_ram_en",   64'(ram_en),   64'd0);
      chk("rst_ram_we",   64'(ram_we),   64'd0);
      chk("rst_ram_addr", 64'(ram_addr), 64'd0);
      chk("rst_ram_di",   64'(ram_di),   64'd0);

      // C read only
      next_cycle(); rst = 1'b0;
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10; settle();
      chk("cr_stall",    64'(c_stall),  64'd0);
      chk("cr_ram_en",   64'(ram_en),   64'd1);
      chk("cr_ram_addr", 64'(ram_addr), 64'h10);
      next_cycle(); c_req = 1'b0; settle();
      chk("cr_rvalid",   64'(c_rvalid), 64'd1);
      chk("cr_rdata",    64'(c_rdata),  64'hDEADBEEF);
      chk("cr_l_rvalid", 64'(l_rvalid), 64'd0);

      // Contention: C read wins, L write waits one cycle
      next_cycle();
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
      l_req = 1'b1; l_we = 1'b1; l_addr = 32'h20; l_wdata = 32'h5; settle();
      chk("ct_l_gnt",    64'(l_gnt),    64'd0);
      chk("ct_c_stall",  64'(c_stall),  64'd0);
      chk("ct_addr_c",   64'(ram_addr), 64'h10);
      next_cycle(); c_req = 1'b0; settle();
      chk("ct_l_gnt2",   64'(l_gnt),    64'd1);
      chk("ct_ram_we",   64'(ram_we),   64'd1);
      chk("ct_addr_l",   64'(ram_addr), 64'h20);
      chk("ct_ram_di",   64'(ram_di),   64'h5);
      next_cycle(); l_req = 1'b0; l_we = 1'b0; settle();
      chk("ct_mem",      64'(mem[8'h08]), 64'h5);
      chk("ct_c_rv",     64'(c_rvalid), 64'd0);
      chk("ct_l_rv",     64'(l_rvalid), 64'd0);

      // Interleaved reads C, L, C
      next_cycle(); c_req = 1'b1; c_we = 1'b0; c_addr = 32'h0; settle();
      chk("il_c0_stall", 64'(c_stall), 64'd0);
      next_cycle(); c_req = 1'b0; l_req = 1'b1; l_we = 1'b0; l_addr = 32'h4; settle();
      chk("il_l_gnt",    64'(l_gnt),    64'd1);
      chk("il_c_rv1",    64'(c_rvalid), 64'd1);
      chk("il_l_rv1",    64'(l_rvalid), 64'd0);
      chk("il_c_data1",  64'(c_rdata),  64'h11111111);
      next_cycle(); l_req = 1'b0; c_req = 1'b1; c_addr = 32'h8; settle();
      chk("il_c_rv2",    64'(c_rvalid), 64'd0);
      chk("il_l_rv2",    64'(l_rvalid), 64'd1);
      chk("il_l_data2",  64'(l_rdata),  64'h22222222);
      next_cycle(); c_req = 1'b0; settle();
      chk("il_c_rv3",    64'(c_rvalid), 64'd1);
      chk("il_l_rv3",    64'(l_rvalid), 64'd0);
      chk("il_c_data3",  64'(c_rdata),  64'h33333333);

      // Starvation: C held high, L requesting from cycle 0
      next_cycle();
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h0;
      l_req = 1'b1; l_we = 1'b0; l_addr = 32'h4;
`ifdef ARB_STARVE_GUARD_EN
      for (int cyc = 0; cyc <= 9; cyc++) begin
         settle();
         chk($sformatf("sg_l_gnt_%0d", cyc),   64'(l_gnt),   (cyc == 8) ? 64'd1 : 64'd0);
         chk($sformatf("sg_c_stall_%0d", cyc), 64'(c_stall), (cyc == 8) ? 64'd1 : 64'd0);
         next_cycle();
         if (cyc == 8) l_req = 1'b0;
         if (cyc == 9) begin
            chk("sg_l_rvalid", 64'(l_rvalid), 64'd0);
            chk("sg_c_rvalid", 64'(c_rvalid), 64'd1);
         end
      end
`else
      lg_cnt = 0;
      st_cnt = 0;
      for (int cyc = 0; cyc < 50; cyc++) begin
         settle();
         if (l_gnt)   lg_cnt++;
         if (c_stall) st_cnt++;
         next_cycle();
      end
      chk("ng_l_gnt_cnt",   64'(lg_cnt), 64'd0);
      chk("ng_c_stall_cnt", 64'(st_cnt), 64'd0);
      c_req = 1'b0; settle();
      chk("ng_l_gnt_rel", 64'(l_gnt), 64'd1);
      next_cycle(); l_req = 1'b0; settle();
      chk("ng_l_rvalid",  64'(l_rvalid), 64'd1);
      chk("ng_l_rdata",   64'(l_rdata),  64'h22222222);
`endif

      // Reset mid-read
      next_cycle(); c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10; l_req = 1'b0; settle();
      chk("rm_ram_en", 64'(ram_en), 64'd1);
      next_cycle(); c_req = 1'b0; rst = 1'b1; settle();
      chk("rm_c_rv_in_rst", 64'(c_rvalid), 64'd0);
      next_cycle(); rst = 1'b0; settle();
      chk("rm_c_rv_after", 64'(c_rvalid), 64'd0);
      chk("rm_l_rv_after", 64'(l_rvalid), 64'd0);
      chk("rm_c_stall",    64'(c_stall),  64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
